// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy counter: channel FSM states and a popcount helper.
// Build option: DEBOUNCE_EN (see dir_detect) adds per-input debounce filters.
package occupancy_pkg;

  // Direction-decoder states; E* walk an entry (a then b), X* walk an exit
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    WAIT = 3'd7
  } ch_state_e;

  localparam int MAX_CH = 8;

  function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/dir_detect.sv
// One door: synchronise the two beam sensors, optionally debounce them, and
// decode full a->ab->b->none passes into single-cycle entry/exit pulses.
// Build option: DEBOUNCE_EN enables a DB_CYCLES stability filter per sensor.
module dir_detect
  import occupancy_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef DEBOUNCE_EN
  , parameter int DB_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sumar,
  output logic restar
);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;
  logic [1:0]             s_sync;
  logic [1:0]             s;

  // shift raw async inputs through the synchroniser chain
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
  end

  // synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
    end
  end

  assign s_sync = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);

  logic [1:0]          filt_q, filt_d;
  logic [1:0][DBW-1:0] cnt_q, cnt_d;

  // follow the synchronised bit only after it has disagreed for DB_CYCLES clocks in a row
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s_sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
        filt_d[i] = s_sync[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  // debounce state
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = s_sync;
`endif

  ch_state_e state_q, state_d;
  logic      sumar_q, sumar_d, restar_q, restar_d;

  // direction FSM; s is {a,b}. Pulses fire on the final all-clear after a complete pass
  always_comb begin
    state_d  = state_q;
    sumar_d  = 1'b0;
    restar_d = 1'b0;
    unique case (state_q)
      IDLE: case (s)
              2'b10:   state_d = E1;
              2'b01:   state_d = X1;
              2'b11:   state_d = WAIT;
              default: state_d = IDLE;
            endcase
      E1:   case (s)
              2'b11:   state_d = E2;
              2'b00:   state_d = IDLE;
              2'b01:   state_d = WAIT;
              default: state_d = E1;
            endcase
      X1:   case (s)
              2'b11:   state_d = X2;
              2'b00:   state_d = IDLE;
              2'b10:   state_d = WAIT;
              default: state_d = X1;
            endcase
      E2:   case (s)
              2'b01:   state_d = E3;
              2'b10:   state_d = E1;
              2'b00:   state_d = IDLE;
              default: state_d = E2;
            endcase
      X2:   case (s)
              2'b10:   state_d = X3;
              2'b01:   state_d = X1;
              2'b00:   state_d = IDLE;
              default: state_d = X2;
            endcase
      E3:   case (s)
              2'b00:   begin state_d = IDLE; sumar_d = 1'b1; end
              2'b11:   state_d = E2;
              2'b10:   state_d = WAIT;
              default: state_d = E3;
            endcase
      X3:   case (s)
              2'b00:   begin state_d = IDLE; restar_d = 1'b1; end
              2'b11:   state_d = X2;
              2'b01:   state_d = WAIT;
              default: state_d = X3;
            endcase
      default: state_d = (s == 2'b00) ? IDLE : WAIT;
    endcase
  end

  // FSM state and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sumar_q  <= 1'b0;
      restar_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sumar_q  <= sumar_d;
      restar_q <= restar_d;
    end
  end

  assign sumar  = sumar_q;
  assign restar = restar_q;

endmodule

// File: rtl/occupancy_counter.sv
// Multi-door occupancy counter: one dir_detect per door, events merged into a
// saturating count with full/empty flags and sticky overflow/underflow.
// Build option: DEBOUNCE_EN adds debounce filters inside every channel.
module occupancy_counter
  import occupancy_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int MAX_OCC     = 200,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  a,
  input  logic [N_CH-1:0]  b,
  input  logic             clear,
  output logic [N_CH-1:0]  sumar,
  output logic [N_CH-1:0]  restar,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  if (N_CH < 1 || N_CH > MAX_CH || MAX_OCC >= 2**CNT_W || SYNC_STAGES < 2 || DB_CYCLES < 1)
  begin : g_param_err
    $error("occupancy_counter: illegal parameter combination");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    dir_detect #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef DEBOUNCE_EN
      , .DB_CYCLES(DB_CYCLES)
`endif
    ) u_dir (
      .clk    (clk),
      .rst    (rst),
      .a      (a[g]),
      .b      (b[g]),
      .sumar  (sumar[g]),
      .restar (restar[g])
    );
  end

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0]       n_add, n_sub;
  int               sum;

  assign n_add = popcount(MAX_CH'(sumar));
  assign n_sub = popcount(MAX_CH'(restar));

  // net delta of all doors, clamped; clear overrides any pending delta
  always_comb begin
    sum   = int'(occ_q) + int'(n_add) - int'(n_sub);
    occ_d = occ_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      occ_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (sum > MAX_OCC) begin
      occ_d = CNT_W'(MAX_OCC);
      ovf_d = 1'b1;
    end else if (sum < 0) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else begin
      occ_d = CNT_W'(sum);
    end
  end

  // occupancy count and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == CNT_W'(MAX_OCC));
  assign empty     = (occ_q == '0);
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed bench for occupancy_counter: a vector table of single-door passes
// plus hand sequences for latency, reset mid-pass, clear, saturation and
// (with DEBOUNCE_EN) glitch rejection. A second instance uses MAX_OCC=3.
module tb_occupancy_counter;

  localparam int HOLD = 10;
`ifdef DEBOUNCE_EN
  localparam int EXP_LAT = 3 + 4;
`else
  localparam int EXP_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic       clear = 1'b0;

  logic [3:0] sumar, restar, sumar3, restar3;
  logic [7:0] occ, occ3;
  logic       full, empty, ovf, unf, full3, empty3, ovf3, unf3;

  always #5 clk = ~clk;

  occupancy_counter dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clear(clear),
    .sumar(sumar), .restar(restar), .occupancy(occ),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  occupancy_counter #(.MAX_OCC(3)) dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clear(clear),
    .sumar(sumar3), .restar(restar3), .occupancy(occ3),
    .full(full3), .empty(empty3), .ovf(ovf3), .unf(unf3)
  );

  int n_chk = 0, n_pass = 0;
  int sc[4] = '{0, 0, 0, 0};
  int rc[4] = '{0, 0, 0, 0};
  int wide = 0;
  logic [3:0] prev_s = '0, prev_r = '0;

  // count pulses per channel and catch any pulse longer than one clock
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sumar[i])  sc[i] = sc[i] + 1;
      if (restar[i]) rc[i] = rc[i] + 1;
      if ((sumar[i] && prev_s[i]) || (restar[i] && prev_r[i])) wide = wide + 1;
    end
    prev_s = sumar;
    prev_r = restar;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_pass(input int ch, input int n, input logic [11:0] pats);
    logic [1:0] p;
    for (int k = 0; k < n; k++) begin
      p = pats[11-2*k -: 2];
      a[ch] = p[1];
      b[ch] = p[0];
      repeat (HOLD) @(negedge clk);
    end
  endtask

  // entry on ce and exit on cx, aligned so both pulses land in the same cycle
  task automatic run_pair(input int ce, input int cx);
    logic [11:0] pe, px;
    pe = 12'b10_11_01_00_00_00;
    px = 12'b01_11_10_00_00_00;
    for (int k = 0; k < 4; k++) begin
      a[ce] = pe[11-2*k]; b[ce] = pe[10-2*k];
      a[cx] = px[11-2*k]; b[cx] = px[10-2*k];
      repeat (HOLD) @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " occ"},    int'(occ), 0);
    chk({tag, " empty"},  int'(empty), 1);
    chk({tag, " full"},   int'(full), 0);
    chk({tag, " ovf"},    int'(ovf), 0);
    chk({tag, " unf"},    int'(unf), 0);
    chk({tag, " pulses"}, int'({sumar, restar}), 0);
  endtask

  typedef struct {
    int         ch;
    int         n;
    logic [11:0] pats;
    int         es;
    int         er;
    int         occ;
    logic       emp;
    logic       unf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int s0, r0, lat, found;

    vecs[0]  = '{0, 4, 12'b10_11_01_00_00_00, 1, 0, 1, 1'b0, 1'b0}; // entry
    vecs[1]  = '{1, 4, 12'b01_11_10_00_00_00, 0, 1, 0, 1'b1, 1'b0}; // exit
    vecs[2]  = '{2, 2, 12'b11_00_00_00_00_00, 0, 0, 0, 1'b1, 1'b0}; // both at once -> WAIT
    vecs[3]  = '{2, 3, 12'b10_01_00_00_00_00, 0, 0, 0, 1'b1, 1'b0}; // E1 jump -> WAIT
    vecs[4]  = '{3, 4, 12'b01_11_10_00_00_00, 0, 1, 0, 1'b1, 1'b1}; // exit at 0 -> unf
    vecs[5]  = '{0, 6, 12'b10_11_10_11_01_00, 1, 0, 1, 1'b0, 1'b1}; // E2->E1 backtrack
    vecs[6]  = '{1, 6, 12'b01_11_01_11_10_00, 0, 1, 0, 1'b1, 1'b1}; // X2->X1 backtrack
    vecs[7]  = '{3, 2, 12'b10_00_00_00_00_00, 0, 0, 0, 1'b1, 1'b1}; // abort from E1
    vecs[8]  = '{2, 6, 12'b10_11_01_11_01_00, 1, 0, 1, 1'b0, 1'b1}; // E3->E2->E3
    vecs[9]  = '{0, 5, 12'b10_11_01_10_00_00, 0, 0, 1, 1'b0, 1'b1}; // E3 -> WAIT
    vecs[10] = '{1, 3, 12'b10_11_00_00_00_00, 0, 0, 1, 1'b0, 1'b1}; // E2 -> IDLE

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset dut3 empty", int'(empty3), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      s0 = sc[vecs[i].ch];
      r0 = rc[vecs[i].ch];
      run_pass(vecs[i].ch, vecs[i].n, vecs[i].pats);
      chk($sformatf("v%0d sumar", i),  sc[vecs[i].ch] - s0, vecs[i].es);
      chk($sformatf("v%0d restar", i), rc[vecs[i].ch] - r0, vecs[i].er);
      chk($sformatf("v%0d occ", i),    int'(occ), vecs[i].occ);
      chk($sformatf("v%0d empty", i),  int'(empty), int'(vecs[i].emp));
      chk($sformatf("v%0d unf", i),    int'(unf), int'(vecs[i].unf));
    end

    // latency from raw all-clear to pulse, then to count update (occ 1 -> 2)
    run_pass(0, 3, 12'b10_11_01_00_00_00);
    a[0] = 1'b0; b[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (sumar[0]) begin lat = k; break; end
    end
    chk("pulse latency", lat, EXP_LAT);
    chk("occ before update", int'(occ), 1);
    @(negedge clk);
    chk("occ after update", int'(occ), 2);
    repeat (HOLD) @(negedge clk);

    // reset in the middle of an entry: partial pass must not count
    s0 = sc[0];
    run_pass(0, 2, 12'b10_11_00_00_00_00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("mid-pass rst");
    rst = 1'b0;
    run_pass(0, 2, 12'b01_00_00_00_00_00);
    chk("post-rst no sumar", sc[0] - s0, 0);
    chk("post-rst occ", int'(occ), 0);

    // clear coinciding with an entry pulse: clear wins, unf also cleared
    run_pass(3, 4, 12'b01_11_10_00_00_00);
    run_pass(0, 4, 12'b10_11_01_00_00_00);
    chk("pre-clear occ", int'(occ), 1);
    chk("pre-clear unf", int'(unf), 1);
    run_pass(1, 3, 12'b10_11_01_00_00_00);
    a[1] = 1'b0; b[1] = 1'b0;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sumar[1]) begin found = 1; break; end
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear saw pulse", found, 1);
    chk("clear beats delta occ", int'(occ), 0);
    chk("clear unf", int'(unf), 0);
    repeat (HOLD) @(negedge clk);

    // simultaneous entry + exit at zero cancel without a flag
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_pair(0, 1);
    chk("cancel@0 occ", int'(occ), 0);
    chk("cancel@0 unf", int'(unf), 0);
    chk("cancel@0 dut3 unf", int'(unf3), 0);

    // saturation on the MAX_OCC=3 instance
    for (int i = 0; i < 3; i++) run_pass(2, 4, 12'b10_11_01_00_00_00);
    chk("sat3 occ", int'(occ3), 3);
    chk("sat3 full", int'(full3), 1);
    chk("sat3 ovf", int'(ovf3), 0);
    run_pass(2, 4, 12'b10_11_01_00_00_00);
    chk("sat4 occ", int'(occ3), 3);
    chk("sat4 ovf", int'(ovf3), 1);
    chk("sat4 dut occ", int'(occ), 4);
    chk("sat4 dut full", int'(full), 0);
    run_pair(0, 1);
    chk("cancel@full occ", int'(occ3), 3);
    chk("cancel@full dut occ", int'(occ), 4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear dut3 occ", int'(occ3), 0);
    chk("clear dut3 ovf", int'(ovf3), 0);
    chk("clear dut3 empty", int'(empty3), 1);
    chk("clear dut3 full", int'(full3), 0);

`ifdef DEBOUNCE_EN
    // a one-clock drop of a while in X3 must not look like a completed exit
    r0 = rc[2];
    run_pass(2, 3, 12'b01_11_10_00_00_00);
    a[2] = 1'b0;
    @(negedge clk);
    a[2] = 1'b1;
    repeat (HOLD) @(negedge clk);
    run_pass(2, 3, 12'b11_01_00_00_00_00);
    chk("glitch no restar", rc[2] - r0, 0);
    chk("glitch occ", int'(occ), 0);
`endif

    chk("pulse width", wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
